i2c_target_regs: RTL and testbench

I2C_TARGET_REGS -- requirements
Module: i2c_target_regs

---
 rtl/i2c_pkg.sv | 18 +
 rtl/i2c_line_sync.sv | 37 +++
 rtl/i2c_target_regs.sv | 211 +++++++++++++++++++++
 tb/tb_i2c_target_regs.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared constants and state encoding for the I2C register target.
package i2c_pkg;

  localparam int NREGS = 16;
  localparam int PTR_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_BYTE,
    WR_ACK,
    RD_BYTE,
    RD_ACK,
    IGNORE
  } state_t;

endpackage

// File: rtl/i2c_line_sync.sv
// Two-flop synchronizer plus history flop for one open-drain bus line.
// Resets to 1 so an idle bus produces no edges after reset.
module i2c_line_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic pin_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta_q, sync_q, hist_q;
  logic meta_d, sync_d, hist_d;

  always_comb begin
    meta_d = pin_in;
    sync_d = meta_q;
    hist_d = sync_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      hist_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  assign level = sync_q;
  assign rise  = sync_q & ~hist_q;
  assign fall  = ~sync_q & hist_q;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target exposing a 16 x 8-bit register file with an auto-incrementing
// pointer; first written byte after the address sets the pointer.
module i2c_target_regs
  import i2c_pkg::*;
#(
  parameter logic [6:0] TARGET_ADDR = 7'h0A
) (
  input  logic                 clk_clk,
  input  logic                 reset_reset_n,
  input  logic                 scl_in,
  input  logic                 sda_in,
  output logic                 sda_oe,
  output logic                 scl_oe,
  output logic [8*NREGS-1:0]   regs_flat,
  output logic                 wr_strobe,
  output logic [PTR_W-1:0]     wr_index,
  output logic                 busy
);

  logic scl_level, scl_rise, scl_fall;
  logic sda_level, sda_rise, sda_fall;
  logic start_det, stop_det;

  i2c_line_sync u_scl_sync (
    .clk    (clk_clk),
    .rst_n  (reset_reset_n),
    .pin_in (scl_in),
    .level  (scl_level),
    .rise   (scl_rise),
    .fall   (scl_fall)
  );

  i2c_line_sync u_sda_sync (
    .clk    (clk_clk),
    .rst_n  (reset_reset_n),
    .pin_in (sda_in),
    .level  (sda_level),
    .rise   (sda_rise),
    .fall   (sda_fall)
  );

  assign start_det = scl_level & sda_fall;
  assign stop_det  = scl_level & sda_rise;

  state_t            state_q, state_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic              ptr_loaded_q, ptr_loaded_d;
  logic              nack_q, nack_d;
  logic              sda_oe_q, sda_oe_d;
  logic              wr_strobe_q, wr_strobe_d;
  logic [PTR_W-1:0]  wr_index_q, wr_index_d;
  logic              busy_q, busy_d;
  logic [7:0]        regs_q [NREGS];
  logic [7:0]        regs_d [NREGS];
  logic [7:0]        wr_byte;

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    ptr_d        = ptr_q;
    ptr_loaded_d = ptr_loaded_q;
    nack_d       = nack_q;
    sda_oe_d     = sda_oe_q;
    wr_strobe_d  = 1'b0;
    wr_index_d   = wr_index_q;
    busy_d       = busy_q;
    regs_d       = regs_q;
    wr_byte      = {shift_q[6:0], sda_level};

    // Bus conditions override whatever byte is in flight.
    if (start_det) begin
      state_d      = ADDR;
      bit_cnt_d    = 4'd0;
      sda_oe_d     = 1'b0;
      ptr_loaded_d = 1'b0;
      busy_d       = 1'b1;
    end else if (stop_det) begin
      state_d  = IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      case (state_q)
        ADDR: begin
          if (scl_rise && bit_cnt_q != 4'd8) begin
            shift_d   = wr_byte;
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            if (shift_q[7:1] == TARGET_ADDR) begin
              state_d  = ADDR_ACK;
              sda_oe_d = 1'b1;
            end else begin
              state_d = IGNORE;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            bit_cnt_d = 4'd0;
            if (shift_q[0]) begin
              state_d  = RD_BYTE;
              shift_d  = regs_q[ptr_q];
              sda_oe_d = ~regs_q[ptr_q][7];
            end else begin
              state_d  = WR_BYTE;
              sda_oe_d = 1'b0;
            end
          end
        end
        WR_BYTE: begin
          if (scl_rise && bit_cnt_q != 4'd8) begin
            shift_d   = wr_byte;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              if (ptr_loaded_q) begin
                regs_d[ptr_q] = wr_byte;
                wr_strobe_d   = 1'b1;
                wr_index_d    = ptr_q;
                ptr_d         = ptr_q + 1'b1;
              end else begin
                ptr_d        = wr_byte[PTR_W-1:0];
                ptr_loaded_d = 1'b1;
              end
            end
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            state_d  = WR_ACK;
            sda_oe_d = 1'b1;
          end
        end
        WR_ACK: begin
          if (scl_fall) begin
            state_d   = WR_BYTE;
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
          end
        end
        RD_BYTE: begin
          if (scl_fall) begin
            if (bit_cnt_q == 4'd7) begin
              state_d   = RD_ACK;
              sda_oe_d  = 1'b0;
              ptr_d     = ptr_q + 1'b1;
              bit_cnt_d = 4'd0;
            end else begin
              shift_d   = {shift_q[6:0], 1'b0};
              sda_oe_d  = ~shift_q[6];
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end
        RD_ACK: begin
          if (scl_rise) begin
            nack_d = sda_level;
          end else if (scl_fall) begin
            if (!nack_q) begin
              state_d   = RD_BYTE;
              shift_d   = regs_q[ptr_q];
              sda_oe_d  = ~regs_q[ptr_q][7];
              bit_cnt_d = 4'd0;
            end else begin
              state_d = IGNORE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q      <= IDLE;
      bit_cnt_q    <= 4'd0;
      shift_q      <= 8'h00;
      ptr_q        <= '0;
      ptr_loaded_q <= 1'b0;
      nack_q       <= 1'b1;
      sda_oe_q     <= 1'b0;
      wr_strobe_q  <= 1'b0;
      wr_index_q   <= '0;
      busy_q       <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= 8'h00;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      ptr_q        <= ptr_d;
      ptr_loaded_q <= ptr_loaded_d;
      nack_q       <= nack_d;
      sda_oe_q     <= sda_oe_d;
      wr_strobe_q  <= wr_strobe_d;
      wr_index_q   <= wr_index_d;
      busy_q       <= busy_d;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= regs_d[i];
    end
  end

  always_comb begin
    regs_flat = '0;
    for (int i = 0; i < NREGS; i++) regs_flat[8*i +: 8] = regs_q[i];
  end

  assign sda_oe    = sda_oe_q;
  assign scl_oe    = 1'b0;
  assign wr_strobe = wr_strobe_q;
  assign wr_index  = wr_index_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Directed bench: bit-banged I2C master on an open-drain SDA model.
module tb_i2c_target_regs;

  localparam int HALF = 20;
  localparam int QTR  = 10;

  logic         clk_clk;
  logic         reset_reset_n;
  logic         scl_m;
  logic         sda_m;
  logic         sda_in;
  logic         sda_oe;
  logic         scl_oe;
  logic [127:0] regs_flat;
  logic         wr_strobe;
  logic [3:0]   wr_index;
  logic         busy;

  int           tests_run;
  int           tests_failed;
  logic [7:0]   exp_regs [16];
  logic [3:0]   strobe_idx [$];
  logic         oe_seen;

  assign sda_in = sda_m & ~sda_oe;

  i2c_target_regs #(.TARGET_ADDR(7'h0A)) dut (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .scl_in        (scl_m),
    .sda_in        (sda_in),
    .sda_oe        (sda_oe),
    .scl_oe        (scl_oe),
    .regs_flat     (regs_flat),
    .wr_strobe     (wr_strobe),
    .wr_index      (wr_index),
    .busy          (busy)
  );

  initial clk_clk = 1'b0;
  always #5 clk_clk = ~clk_clk;

  // Records write strobes and any SDA drive by the target.
  always @(negedge clk_clk) begin
    if (wr_strobe) strobe_idx.push_back(wr_index);
    if (sda_oe) oe_seen = 1'b1;
  end

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] exp_flat();
    logic [127:0] v;
    for (int i = 0; i < 16; i++) v[8*i +: 8] = exp_regs[i];
    return v;
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk_clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wait_clk(QTR);
    scl_m = 1'b1; wait_clk(HALF);
    sda_m = 1'b0; wait_clk(HALF);
    scl_m = 1'b0; wait_clk(QTR);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_clk(QTR);
    scl_m = 1'b1; wait_clk(HALF);
    sda_m = 1'b1; wait_clk(HALF);
  endtask

  task automatic send_bit(input logic b);
    sda_m = b;    wait_clk(QTR);
    scl_m = 1'b1; wait_clk(HALF);
    scl_m = 1'b0; wait_clk(QTR);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    sda_m = 1'b1; wait_clk(QTR);
    scl_m = 1'b1; wait_clk(HALF/2);
    ack = sda_in; wait_clk(HALF/2);
    scl_m = 1'b0; wait_clk(QTR);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    for (int i = 7; i >= 0; i--) begin
      sda_m = 1'b1; wait_clk(QTR);
      scl_m = 1'b1; wait_clk(HALF/2);
      d[i] = sda_in; wait_clk(HALF/2);
      scl_m = 1'b0; wait_clk(QTR);
    end
    send_bit(nack);
  endtask

  initial begin
    logic       a0, a1, a2, a3;
    logic [7:0] rd0, rd1;
    int         n0;

    tests_run = 0;
    tests_failed = 0;
    oe_seen = 1'b0;
    for (int i = 0; i < 16; i++) exp_regs[i] = 8'h00;
    reset_reset_n = 1'b0;
    scl_m = 1'b1;
    sda_m = 1'b1;
    wait_clk(5);

    checkOutput("reset_sda_oe", {127'd0, sda_oe}, 128'd0);
    checkOutput("reset_scl_oe", {127'd0, scl_oe}, 128'd0);
    checkOutput("reset_busy", {127'd0, busy}, 128'd0);
    checkOutput("reset_wr_strobe", {127'd0, wr_strobe}, 128'd0);
    checkOutput("reset_wr_index", {124'd0, wr_index}, 128'd0);
    checkOutput("reset_regs", regs_flat, 128'd0);

    reset_reset_n = 1'b1;
    wait_clk(10);

    // Write ptr 3, then 0x5A, 0xA5.
    i2c_start();
    checkOutput("busy_after_start", {127'd0, busy}, 128'd1);
    write_byte(8'h14, a0);
    write_byte(8'h03, a1);
    write_byte(8'h5A, a2);
    write_byte(8'hA5, a3);
    i2c_stop();
    wait_clk(5);
    exp_regs[3] = 8'h5A;
    exp_regs[4] = 8'hA5;
    checkOutput("wr_acks", {124'd0, a0, a1, a2, a3}, 128'd0);
    checkOutput("wr_regs", regs_flat, exp_flat());
    checkOutput("wr_strobe_count", 128'(strobe_idx.size()), 128'd2);
    if (strobe_idx.size() >= 2) begin
      checkOutput("wr_index_0", {124'd0, strobe_idx[0]}, 128'd3);
      checkOutput("wr_index_1", {124'd0, strobe_idx[1]}, 128'd4);
    end
    checkOutput("busy_after_stop", {127'd0, busy}, 128'd0);

    // Wrong address must be ignored and never driven.
    oe_seen = 1'b0;
    n0 = strobe_idx.size();
    i2c_start();
    write_byte(8'h0B, a0);
    write_byte(8'h03, a1);
    write_byte(8'hEE, a2);
    i2c_stop();
    wait_clk(5);
    checkOutput("nack_addr", {127'd0, a0}, 128'd1);
    checkOutput("nack_data", {126'd0, a1, a2}, 128'd3);
    checkOutput("nack_regs", regs_flat, exp_flat());
    checkOutput("nack_oe_seen", {127'd0, oe_seen}, 128'd0);
    checkOutput("nack_strobes", 128'(strobe_idx.size() - n0), 128'd0);

    // Pointer write, repeated START, read two bytes.
    i2c_start();
    write_byte(8'h14, a0);
    write_byte(8'h03, a1);
    i2c_start();
    write_byte(8'h15, a2);
    read_byte(1'b0, rd0);
    read_byte(1'b1, rd1);
    wait_clk(5);
    checkOutput("rd_acks", {125'd0, a0, a1, a2}, 128'd0);
    checkOutput("rd_byte0", {120'd0, rd0}, 128'h5A);
    checkOutput("rd_byte1", {120'd0, rd1}, 128'hA5);
    checkOutput("rd_release", {127'd0, sda_oe}, 128'd0);
    i2c_stop();
    wait_clk(5);
    checkOutput("rd_busy_low", {127'd0, busy}, 128'd0);

    // Pointer and register wrap 15 -> 0.
    n0 = strobe_idx.size();
    i2c_start();
    write_byte(8'h14, a0);
    write_byte(8'h0F, a1);
    write_byte(8'h11, a2);
    write_byte(8'h22, a3);
    i2c_stop();
    wait_clk(5);
    exp_regs[15] = 8'h11;
    exp_regs[0]  = 8'h22;
    checkOutput("wrap_acks", {124'd0, a0, a1, a2, a3}, 128'd0);
    checkOutput("wrap_regs", regs_flat, exp_flat());
    checkOutput("wrap_strobe_count", 128'(strobe_idx.size() - n0), 128'd2);
    if (strobe_idx.size() >= n0 + 2) begin
      checkOutput("wrap_index_0", {124'd0, strobe_idx[n0]}, 128'd15);
      checkOutput("wrap_index_1", {124'd0, strobe_idx[n0+1]}, 128'd0);
    end

    // STOP after 4 data bits aborts the byte.
    n0 = strobe_idx.size();
    i2c_start();
    write_byte(8'h14, a0);
    write_byte(8'h04, a1);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    i2c_stop();
    wait_clk(5);
    checkOutput("abort_strobes", 128'(strobe_idx.size() - n0), 128'd0);
    checkOutput("abort_regs", regs_flat, exp_flat());
    checkOutput("abort_busy", {127'd0, busy}, 128'd0);
    checkOutput("abort_oe", {127'd0, sda_oe}, 128'd0);

    // Reset while the target drives the address ACK.
    i2c_start();
    for (int i = 7; i >= 0; i--) send_bit(((8'h14 >> i) & 8'h01) != 8'h00);
    sda_m = 1'b1; wait_clk(QTR);
    scl_m = 1'b1; wait_clk(HALF/2);
    checkOutput("ack_driven_pre_reset", {127'd0, sda_oe}, 128'd1);
    #1 reset_reset_n = 1'b0;
    #1;
    checkOutput("reset_async_release", {127'd0, sda_oe}, 128'd0);
    checkOutput("reset_clears_regs", regs_flat, 128'd0);
    checkOutput("reset_clears_busy", {127'd0, busy}, 128'd0);
    for (int i = 0; i < 16; i++) exp_regs[i] = 8'h00;
    wait_clk(3);
    reset_reset_n = 1'b1;
    wait_clk(HALF/2);
    scl_m = 1'b0;
    wait_clk(HALF);

    n0 = strobe_idx.size();
    i2c_start();
    write_byte(8'h14, a0);
    write_byte(8'h07, a1);
    write_byte(8'h77, a2);
    i2c_stop();
    wait_clk(5);
    exp_regs[7] = 8'h77;
    checkOutput("post_reset_acks", {125'd0, a0, a1, a2}, 128'd0);
    checkOutput("post_reset_regs", regs_flat, exp_flat());
    checkOutput("post_reset_strobes", 128'(strobe_idx.size() - n0), 128'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
